// File: rtl/timer_pkg.sv
// timer_pkg: definitions shared by the timer blocks.
//   TIMER_WIDTH   - default divider / count width
//   timer_state_e - control FSM state encoding (IDLE, RUN, DONE)
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 12;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler_if.sv
// tick_prescaler_if: divide-ratio load handshake.
//   div_val  - new divide ratio R (tick period is R+1 clocks)
//   div_load - strobe, sample div_val this cycle
//   div_ack  - one-cycle acknowledge, the cycle after each sampled strobe
// master = ratio source, slave = prescaler.
interface tick_prescaler_if #(
  parameter int unsigned WIDTH = timer_pkg::TIMER_WIDTH
);
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_ack;

  modport master (output div_val, output div_load, input div_ack);
  modport slave  (input div_val, input div_load, output div_ack);
endinterface

// File: rtl/tick_prescaler_ctr.sv
// tick_prescaler_ctr: down-counter with reload.
//   clk, rst_n - clock, synchronous active-low reset
//   clear      - force count to zero (highest priority after reset)
//   load       - load load_val
//   dec        - decrement by one, saturating at zero
//   cnt        - current count
//   zero       - cnt == 0
module tick_prescaler_ctr #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable tick generator, one tick every R+1 clocks.
//   clk, rst_n - clock, synchronous active-low reset
//   en         - run request (high = count, low = stop, back to IDLE)
//   cfg        - ratio load handshake (div_val / div_load / div_ack)
//   tick       - registered one-cycle enable pulse
//   cnt        - current down-count value
//   oneshot    - only with TICK_PRESCALER_ONESHOT_EN: stop after first tick
//   busy       - high while in RUN
// Optional feature macro: TICK_PRESCALER_ONESHOT_EN (adds oneshot, DONE state).
//
// state | meaning
// IDLE  | stopped, cnt=0, ratio loads apply immediately
// RUN   | counting, ratio loads go to the shadow until the next reload
// DONE  | one-shot finished, waiting for en=0
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned      WIDTH   = TIMER_WIDTH,
  parameter logic [WIDTH-1:0] DEF_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  tick_prescaler_if.slave  cfg,
  output logic             tick,
  output logic [WIDTH-1:0] cnt,
`ifdef TICK_PRESCALER_ONESHOT_EN
  input  logic             oneshot,
`endif
  output logic             busy
);

  localparam logic [1:0] IDLE = TS_IDLE;
  localparam logic [1:0] RUN  = TS_RUN;
  localparam logic [1:0] DONE = TS_DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] ratio;
  logic [WIDTH-1:0] shadow;
  logic             shadow_vld;
  logic [WIDTH-1:0] reload_val;
  logic             oneshot_act;
  logic             enter_evt;
  logic             reload_evt;
  logic             done_evt;
  logic             ctr_clear;
  logic             ctr_load;
  logic             ctr_dec;
  logic             cnt_zero;

`ifdef TICK_PRESCALER_ONESHOT_EN
  assign oneshot_act = oneshot;
`else
  assign oneshot_act = 1'b0;
`endif

  // A strobe landing on a reload beats the shadow; the shadow beats the
  // active ratio.
  always_comb begin
    reload_val = ratio;
    if (cfg.div_load) begin
      reload_val = cfg.div_val;
    end else if (shadow_vld) begin
      reload_val = shadow;
    end
  end

  // One-shot leaves RUN the cycle after its tick, so tick is never high
  // while in DONE.
  assign done_evt   = (state == RUN) && en && oneshot_act && tick;
  assign enter_evt  = (state == IDLE) && en;
  assign reload_evt = (state == RUN) && en && !done_evt && cnt_zero;
  assign ctr_clear  = !en || done_evt;
  assign ctr_load   = enter_evt || reload_evt;
  assign ctr_dec    = (state == RUN) && en && !done_evt && !cnt_zero;

  assign busy = (state == RUN);

  tick_prescaler_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (reload_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= 1'b0;
      cfg.div_ack <= 1'b0;
      ratio      <= DEF_DIV;
      shadow     <= '0;
      shadow_vld <= 1'b0;
    end else begin
      cfg.div_ack <= cfg.div_load;
      tick        <= reload_evt;

      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end else if (done_evt) begin
            state <= DONE;
          end
        end
        DONE: if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (ctr_load) begin
        ratio      <= reload_val;
        shadow_vld <= 1'b0;
      end else if (cfg.div_load) begin
        if (state == RUN) begin
          shadow     <= cfg.div_val;
          shadow_vld <= 1'b1;
        end else begin
          ratio      <= cfg.div_val;
          shadow_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed stimulus; expected tick/ack cycles are queued
// at stimulus time and a negedge monitor pops them as the DUT pulses.
module tb_tick_prescaler;
  import timer_pkg::*;

  localparam int W = TIMER_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         tick;
  logic         busy;
  logic [W-1:0] cnt;
`ifdef TICK_PRESCALER_ONESHOT_EN
  logic         oneshot;
`endif

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int exp_tick[$];
  int exp_ack[$];

  tick_prescaler_if #(.WIDTH(W)) cfg_if ();

  tick_prescaler #(.WIDTH(W), .DEF_DIV({W{1'b0}})) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg_if),
    .tick    (tick),
    .cnt     (cnt),
`ifdef TICK_PRESCALER_ONESHOT_EN
    .oneshot (oneshot),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    int e;
    if (tick === 1'b1) begin
      checks++;
      if (exp_tick.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
      end else begin
        e = exp_tick.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL tick_cycle: tick at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
    if (cfg_if.div_ack === 1'b1) begin
      checks++;
      if (exp_ack.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: div_ack at cycle %0d, none expected", cyc);
      end else begin
        e = exp_ack.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL ack_cycle: div_ack at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_div(input int v);
    cfg_if.div_val  = W'(v);
    cfg_if.div_load = 1'b1;
    exp_ack.push_back(cyc + 1);
    step(1);
    cfg_if.div_load = 1'b0;
  endtask

  // Run continuously for n periods of ratio r, then stop.
  task automatic run_cont(input int r, input int n, input string name);
    int e;
    e  = cyc + 1;
    en = 1'b1;
    for (int k = 1; k <= n; k++) exp_tick.push_back(e + (r + 1) * k);
    step((r + 1) * n + 1);
    en = 1'b0;
    step(1);
    chk({name, "_tick_after_stop"}, int'(tick), 0);
    chk({name, "_busy_after_stop"}, int'(busy), 0);
    chk({name, "_cnt_after_stop"}, int'(cnt), 0);
  endtask

  initial begin
    int e;
    rst_n           = 1'b0;
    en              = 1'b0;
    cfg_if.div_val  = '0;
    cfg_if.div_load = 1'b0;
`ifdef TICK_PRESCALER_ONESHOT_EN
    oneshot = 1'b0;
`endif
    step(3);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack", int'(cfg_if.div_ack), 0);
    rst_n = 1'b1;
    step(1);

    // Period with R=3: ticks every 4 cycles.
    load_div(3);
    run_cont(3, 11, "r3");

    // R=0: tick on every cycle after entry, low right after stop.
    load_div(0);
    run_cont(0, 6, "r0");

    // Strobe held three cycles: three acks, last value (1) wins.
    cfg_if.div_load = 1'b1;
    cfg_if.div_val  = W'(5);
    exp_ack.push_back(cyc + 1);
    step(1);
    cfg_if.div_val = W'(6);
    exp_ack.push_back(cyc + 1);
    step(1);
    cfg_if.div_val = W'(1);
    exp_ack.push_back(cyc + 1);
    step(1);
    cfg_if.div_load = 1'b0;
    run_cont(1, 3, "held");

    // Shadow load: R=7 running, load 2 mid-period.
    load_div(7);
    e  = cyc + 1;
    en = 1'b1;
    exp_tick.push_back(e + 8);
    exp_tick.push_back(e + 16);
    exp_tick.push_back(e + 19);
    exp_tick.push_back(e + 22);
    step(12);
    chk("shadow_busy", int'(busy), 1);
    load_div(2);
    step(10);
    en = 1'b0;
    step(2);

    // Coincident load: R=4, load 1 on the cycle cnt==0.
    load_div(4);
    e  = cyc + 1;
    en = 1'b1;
    exp_tick.push_back(e + 5);
    exp_tick.push_back(e + 10);
    exp_tick.push_back(e + 12);
    exp_tick.push_back(e + 14);
    step(10);
    chk("coincident_cnt_zero", int'(cnt), 0);
    load_div(1);
    step(4);
    en = 1'b0;
    step(2);

    // Reset mid-count with R=5, en held high throughout.
    load_div(5);
    e  = cyc + 1;
    en = 1'b1;
    step(4);
    chk("midcount_cnt", int'(cnt), 2);
    rst_n = 1'b0;
    step(3);
    chk("midreset_cnt", int'(cnt), 0);
    chk("midreset_tick", int'(tick), 0);
    chk("midreset_busy", int'(busy), 0);
    rst_n = 1'b1;
    e = cyc + 1;
    for (int k = 1; k <= 4; k++) exp_tick.push_back(e + k);
    step(5);
    en = 1'b0;
    step(2);

`ifdef TICK_PRESCALER_ONESHOT_EN
    // One-shot: a single tick, then silence until en toggles.
    oneshot = 1'b1;
    load_div(2);
    e  = cyc + 1;
    en = 1'b1;
    exp_tick.push_back(e + 3);
    step(5);
    chk("oneshot_busy_drop", int'(busy), 0);
    step(6);
    en = 1'b0;
    step(1);
    e  = cyc + 1;
    en = 1'b1;
    exp_tick.push_back(e + 3);
    step(5);
    chk("oneshot_rearm_busy_drop", int'(busy), 0);
    en      = 1'b0;
    oneshot = 1'b0;
    step(2);
`endif

    step(3);
    chk("tick_queue_empty", exp_tick.size(), 0);
    chk("ack_queue_empty", exp_ack.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 SHALL have parameter WIDTH, default 12, divider and count width.
REQ-002 SHALL have parameter DEF_DIV, default 12'd0, divide ratio loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  input  1  run request; high = count, low = stop.
REQ-006 SHALL have port div_val  input  WIDTH  divide ratio R; tick period is R+1 clk cycles.
REQ-007 SHALL have port div_load  input  1  strobe: sample div_val this cycle.
REQ-008 SHALL have port div_ack  output  1  one-cycle acknowledge of each sampled div_load.
REQ-009 SHALL have port tick  output  1  registered one-cycle enable pulse for the downstream timer.
REQ-010 SHALL have port cnt  output  WIDTH  current down-count value.
REQ-011 SHALL have port busy  output  1  high while state is RUN.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN when en=1; RUN->IDLE and DONE->IDLE when en=0.
REQ-013 SHALL, on the IDLE->RUN edge, load cnt with the active ratio R.
REQ-014 SHALL, in RUN with cnt!=0, decrement cnt by 1 per cycle, with no wrap below 0.
REQ-015 SHALL, in RUN with cnt==0, reload cnt with R and drive tick=1 for exactly that next cycle.
REQ-016 SHALL produce the first tick R+1 cycles after entering RUN, then one tick every R+1 cycles.
REQ-017 SHALL, for R=0, hold tick high on every cycle in RUN after the entry cycle.
REQ-018 SHALL, on div_load in IDLE, apply the new R immediately.
REQ-019 SHALL, on div_load in RUN, place the value in a shadow register and apply it at the next reload.
REQ-020 SHALL, when div_load coincides with a reload, use the new value for that reload.
REQ-021 SHALL assert div_ack on the cycle after every cycle div_load=1; div_load held high N cycles yields N acks, and the last value wins.
REQ-022 SHALL, on en=0, go to IDLE on the next edge with cnt=0 and tick=0, keeping R and any pending shadow value.
REQ-023 SHALL drive busy=1 only in RUN, and tick=0 in IDLE and DONE.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set state=IDLE, cnt=0, tick=0, div_ack=0, busy=0, R=DEF_DIV, and clear the shadow.
REQ-025 SHALL give reset priority over en and div_load, including mid-count; there SHALL be no asynchronous reset path.

Configuration
REQ-026 SHALL, with TICK_PRESCALER_ONESHOT_EN defined, add port oneshot (input, 1); with oneshot=1, RUN->DONE on the first tick, staying in DONE until en=0.
REQ-027 SHALL, without TICK_PRESCALER_ONESHOT_EN, omit the oneshot port and DONE state is unreachable; behaviour is continuous only.

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/DONE) and the default WIDTH constant from shared package timer_pkg.
REQ-029 SHALL place the down-counter with reload in one sub-module, tick_prescaler_ctr; control FSM and ratio/shadow registers stay in the top.

Verification
REQ-030 SHALL check reset: rst_n=0 for 3 cycles mid-count with R=5 -> cnt=0, tick=0, busy=0, and R returns to DEF_DIV.
REQ-031 SHALL check period: load R=3 in IDLE, en=1 -> first tick 4 cycles after entry, then ticks every 4 cycles for 10 periods.
REQ-032 SHALL check R=0: load 0, en=1 -> tick high every cycle after entry; en=0 -> tick low the next cycle.
REQ-033 SHALL check shadow load: R=7 running, load 2 mid-period -> current period stays 8 cycles, following periods 3 cycles, one div_ack per strobe.
REQ-034 SHALL check coincident load: load R=1 on the cycle cnt==0 with R=4 -> reload uses 1, next tick 2 cycles later.
REQ-035 SHALL check one-shot (macro on): oneshot=1, R=2, en=1 -> exactly one tick at 3 cycles; busy drops; no tick until en toggles low then high.
